fifo_v2: RTL and testbench
==========================

FIFO_V2 -- requirements
Module: fifo_v2

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH_WIDTH, default 3, log2 of capacity; capacity = 2**DEPTH_WIDTH words.
REQ-003 Parameter FWFT, default 1; 1 = first-word-fall-through mode, 0 = standard read-latency-1 mode.
REQ-004 Parameter AFULL_THRESH, default 2**DEPTH_WIDTH-1; legal range 1..2**DEPTH_WIDTH.
REQ-005 Parameter AEMPTY_THRESH, default 1; legal range 0..2**DEPTH_WIDTH-1.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 flush  input  1  synchronous clear of contents, excluding configuration.
REQ-009 wr_en  input  1  write request.
REQ-010 din  input  WIDTH  write data.
REQ-011 full  output  1  high when count == 2**DEPTH_WIDTH.
REQ-012 almost_full  output  1  high when count >= AFULL_THRESH.
REQ-013 rd_en  input  1  read request (FWFT: acknowledge of dout; standard: fetch request).
REQ-014 dout  output  WIDTH  read data, registered.
REQ-015 empty  output  1  FWFT: high when dout is not valid; standard: high when count == 0.
REQ-016 almost_empty  output  1  high when count <= AEMPTY_THRESH.
REQ-017 count  output  DEPTH_WIDTH+1  total words held, including a valid FWFT output word.
REQ-018 overflow  output  1  registered one-cycle pulse: write rejected.
REQ-019 underflow  output  1  registered one-cycle pulse: read rejected.

Function
REQ-020 Storage: 2**DEPTH_WIDTH-entry RAM, read/write pointers DEPTH_WIDTH+1 bits wide, wrap modulo 2**(DEPTH_WIDTH+1).
REQ-021 Capacity is exactly 2**DEPTH_WIDTH words in both modes; in FWFT mode the output register word counts toward capacity.
REQ-022 Write accepted when wr_en=1, full=0, flush=0; din stored, count increments (unless a read is also accepted).
REQ-023 wr_en=1 with full=1 and flush=0: data dropped, no state change, overflow=1 on the next cycle only.
REQ-024 full blocks writes even when a read is accepted in the same cycle.
REQ-025 FWFT: when RAM holds data and output register is invalid or being acknowledged, head word loads into dout on the next edge and becomes valid.
REQ-026 FWFT: write at edge N into a completely empty FIFO -> dout=that word and empty=0 after edge N+1.
REQ-027 FWFT: rd_en=1 with empty=0 consumes dout; next word (if any) replaces it on the same edge with no bubble; otherwise empty=1.
REQ-028 Standard: rd_en=1 with count>0 at edge N -> dout = head word after edge N; dout holds otherwise.
REQ-029 rd_en=1 with empty=1 and flush=0: no state change, underflow=1 on the next cycle only.
REQ-030 Simultaneous accepted read and write: count unchanged, both pointers advance.
REQ-031 Write and read on an empty FIFO in the same cycle: write accepted, read rejected with underflow.
REQ-032 almost_full, almost_empty, full, and standard-mode empty are combinational from registered count.
REQ-033 flush=1: pointers, count, and output-valid clear on the next edge; dout retains its value; wr_en/rd_en ignored that cycle; no overflow/underflow pulse.
REQ-034 Pointer wrap: order preserved across any number of wraps; count = wp - rp (+1 when FWFT output valid), truncated to DEPTH_WIDTH+1 bits.

Reset
REQ-035 rst=1 at an edge: pointers=0, count=0, dout=0, output-valid=0, overflow=0, underflow=0; rst overrides flush, wr_en, and rd_en.
REQ-036 After reset: empty=1, full=0, almost_empty=1, almost_full=0 (default parameters).
REQ-037 Reset mid-operation discards all contents; the first post-reset write behaves as a write into an empty FIFO.

Verification
REQ-038 FWFT=1, DEPTH_WIDTH=3: write 0xA5 at edge 1 -> dout=0xA5, empty=0, count=1 after edge 2.
REQ-039 Write 8 words 0x00..0x07, then wr_en with din=0xFF -> full=1, count=8, overflow pulses once; reads return 0x00..0x07 and never 0xFF.
REQ-040 FWFT=0: after writing 0x11, 0x22, hold rd_en for 3 cycles -> dout 0x11, 0x22; third read gives underflow=1 and dout stays 0x22.
REQ-041 Continuous simultaneous read and write for 40 cycles at count=4 -> count stays 4, data in order across pointer wrap.
REQ-042 Half full, assert flush together with wr_en and rd_en -> count=0, empty=1, no overflow or underflow pulse; dout unchanged.
REQ-043 AFULL_THRESH=6, AEMPTY_THRESH=2: fill 0->8 and drain 8->0 -> almost_full high exactly for counts 6..8, almost_empty high exactly for counts 0..2.

Source files
------------

// File: rtl/fifo_v2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fifo_v2                                                |
// | Purpose  : Single-clock FIFO with selectable first-word-fall-     |
// |            through or read-latency-1 output, almost flags and     |
// |            registered overflow/underflow pulses.                  |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module fifo_v2 #(
  parameter int WIDTH         = 8,
  parameter int DEPTH_WIDTH   = 3,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = 2**DEPTH_WIDTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int                 c_CAP_INT = 2**DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] c_CAP    = c_CAP_INT[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] c_AFULL  = AFULL_THRESH[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] c_AEMPTY = AEMPTY_THRESH[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] c_ONE    = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0] c_ZERO   = '0;
  localparam logic                 c_FWFT_MODE = (FWFT != 0);

  logic [WIDTH-1:0]       r_mem [c_CAP_INT];
  logic [DEPTH_WIDTH:0]   r_wp;
  logic [DEPTH_WIDTH:0]   r_rp;
  logic [DEPTH_WIDTH:0]   r_count;
  logic [WIDTH-1:0]       r_dout;
  logic                   r_valid;
  logic                   r_overflow;
  logic                   r_underflow;

  logic [DEPTH_WIDTH:0]   w_ram_cnt;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_load;
  logic                   w_empty;
  logic [DEPTH_WIDTH:0]   w_count_nxt;

  // Words currently sitting in the RAM (excludes the FWFT output word).
  assign w_ram_cnt = r_wp - r_rp;

  // Flags derive only from the registered count so they are glitch-safe.
  assign full         = (r_count == c_CAP);
  assign almost_full  = (r_count >= c_AFULL);
  assign almost_empty = (r_count <= c_AEMPTY);
  assign empty        = w_empty;
  assign count        = r_count;
  assign dout         = r_dout;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Full blocks writes regardless of a same-cycle read; flush masks everything.
  assign w_wr_acc = wr_en & ~full & ~flush;

  generate
    if (FWFT != 0) begin : g_fwft
      // Read acknowledges the word already presented on dout.
      assign w_rd_acc = rd_en & r_valid & ~flush;
      // Refill the output register whenever it is free or being consumed.
      assign w_load   = (w_ram_cnt != c_ZERO) & (~r_valid | w_rd_acc) & ~flush;
      assign w_empty  = ~r_valid;
    end else begin : g_std
      // Read fetches the head word into dout on this edge.
      assign w_rd_acc = rd_en & (r_count != c_ZERO) & ~flush;
      assign w_load   = w_rd_acc;
      assign w_empty  = (r_count == c_ZERO);
    end
  endgenerate

  // Total occupancy moves only on accepted writes and reads.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + c_ONE;
      2'b01:   w_count_nxt = r_count - c_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wp[DEPTH_WIDTH-1:0]] <= din;
    end
  end

  // Pointers, occupancy, output register and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      // dout is deliberately kept; only bookkeeping is cleared.
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & full;
      r_underflow <= rd_en & w_empty;
      r_count     <= w_count_nxt;
      if (w_wr_acc) begin
        r_wp <= r_wp + c_ONE;
      end
      if (w_load) begin
        r_rp    <= r_rp + c_ONE;
        r_dout  <= r_mem[r_rp[DEPTH_WIDTH-1:0]];
        r_valid <= c_FWFT_MODE;
      end else if (w_rd_acc) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_v2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_fifo_v2                                             |
// | Purpose  : Directed self-checking bench for fifo_v2 covering      |
// |            FWFT mode, standard mode and custom almost thresholds. |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_fifo_v2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // FWFT instance, default parameters
  logic       a_flush = 0, a_wr = 0, a_rd = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_full, a_afull, a_empty, a_aempty, a_ovf, a_udf;
  logic [3:0] a_count;

  // Standard-mode instance
  logic       b_flush = 0, b_wr = 0, b_rd = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_full, b_afull, b_empty, b_aempty, b_ovf, b_udf;
  logic [3:0] b_count;

  // Custom thresholds instance
  logic       c_flush = 0, c_wr = 0, c_rd = 0;
  logic [7:0] c_din = 0, c_dout;
  logic       c_full, c_afull, c_empty, c_aempty, c_ovf, c_udf;
  logic [3:0] c_count;

  int total = 0;
  int bad   = 0;
  int q[$];

  fifo_v2 u_fwft (
    .clk(clk), .rst(rst), .flush(a_flush), .wr_en(a_wr), .din(a_din),
    .full(a_full), .almost_full(a_afull), .rd_en(a_rd), .dout(a_dout),
    .empty(a_empty), .almost_empty(a_aempty), .count(a_count),
    .overflow(a_ovf), .underflow(a_udf)
  );

  fifo_v2 #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(b_flush), .wr_en(b_wr), .din(b_din),
    .full(b_full), .almost_full(b_afull), .rd_en(b_rd), .dout(b_dout),
    .empty(b_empty), .almost_empty(b_aempty), .count(b_count),
    .overflow(b_ovf), .underflow(b_udf)
  );

  fifo_v2 #(.AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_thr (
    .clk(clk), .rst(rst), .flush(c_flush), .wr_en(c_wr), .din(c_din),
    .full(c_full), .almost_full(c_afull), .rd_en(c_rd), .dout(c_dout),
    .empty(c_empty), .almost_empty(c_aempty), .count(c_count),
    .overflow(c_ovf), .underflow(c_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1; tick(); rst = 0;
    chk("rst_empty",  a_empty, 1);
    chk("rst_full",   a_full, 0);
    chk("rst_aempty", a_aempty, 1);
    chk("rst_afull",  a_afull, 0);
    chk("rst_count",  a_count, 0);
    chk("rst_dout",   a_dout, 0);
    chk("rst_ovf",    a_ovf, 0);
    chk("rst_udf",    a_udf, 0);
    chk("rst_std_empty", b_empty, 1);

    // ---------------- FWFT first-word latency ----------------
    a_wr = 1; a_din = 8'hA5; tick(); a_wr = 0;
    chk("fwft_e1_empty", a_empty, 1);
    chk("fwft_e1_count", a_count, 1);
    tick();
    chk("fwft_e2_dout",  a_dout, 8'hA5);
    chk("fwft_e2_empty", a_empty, 0);
    chk("fwft_e2_count", a_count, 1);
    a_rd = 1; tick(); a_rd = 0;
    chk("fwft_rd_empty", a_empty, 1);
    chk("fwft_rd_count", a_count, 0);

    // ---------------- FWFT fill, overflow, drain ----------------
    for (int i = 0; i < 8; i++) begin
      a_wr = 1; a_din = 8'(i); tick();
    end
    a_din = 8'hFF; tick(); a_wr = 0;
    chk("fill_full",  a_full, 1);
    chk("fill_count", a_count, 8);
    chk("fill_ovf",   a_ovf, 1);
    tick();
    chk("fill_ovf_once", a_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_dout", a_dout, i);
      a_rd = 1; tick();
    end
    a_rd = 0;
    chk("drain_empty", a_empty, 1);
    chk("drain_count", a_count, 0);
    chk("drain_full",  a_full, 0);

    // ---------------- streaming across pointer wrap ----------------
    for (int i = 0; i < 4; i++) begin
      a_wr = 1; a_din = 8'(8'h10 + i); q.push_back(8'h10 + i); tick();
    end
    a_wr = 0; tick();
    for (int k = 0; k < 40; k++) begin
      chk("stream_dout",  a_dout, q[0]);
      chk("stream_count", a_count, 4);
      a_wr = 1; a_rd = 1; a_din = 8'(8'h14 + k);
      q.push_back(8'h14 + k);
      tick();
      void'(q.pop_front());
    end
    a_wr = 0; a_rd = 0;
    chk("stream_end_count", a_count, 4);
    chk("stream_end_dout",  a_dout, 8'h38);

    // ---------------- flush with wr/rd ----------------
    a_flush = 1; a_wr = 1; a_rd = 1; a_din = 8'hEE; tick();
    a_flush = 0; a_wr = 0; a_rd = 0;
    chk("flush_count", a_count, 0);
    chk("flush_empty", a_empty, 1);
    chk("flush_ovf",   a_ovf, 0);
    chk("flush_udf",   a_udf, 0);
    chk("flush_dout",  a_dout, 8'h38);
    tick();
    chk("flush_wr_ignored", a_empty, 1);

    // ---------------- write+read on empty ----------------
    a_wr = 1; a_rd = 1; a_din = 8'h77; tick(); a_wr = 0; a_rd = 0;
    chk("wrrd_empty_udf",   a_udf, 1);
    chk("wrrd_empty_count", a_count, 1);
    tick();
    chk("wrrd_udf_once", a_udf, 0);
    chk("wrrd_dout",     a_dout, 8'h77);

    // ---------------- reset mid-operation ----------------
    a_wr = 1; a_din = 8'h88; tick();
    rst = 1; a_din = 8'h99; tick(); rst = 0; a_wr = 0;
    chk("midrst_count", a_count, 0);
    chk("midrst_dout",  a_dout, 0);
    chk("midrst_empty", a_empty, 1);
    a_wr = 1; a_din = 8'h5A; tick(); a_wr = 0; tick();
    chk("postrst_dout",  a_dout, 8'h5A);
    chk("postrst_count", a_count, 1);

    // ---------------- standard mode ----------------
    b_wr = 1; b_din = 8'h11; tick(); b_din = 8'h22; tick(); b_wr = 0;
    chk("std_count2", b_count, 2);
    chk("std_notempty", b_empty, 0);
    chk("std_dout_hold", b_dout, 0);
    b_rd = 1; tick();
    chk("std_rd1_dout", b_dout, 8'h11);
    chk("std_rd1_udf",  b_udf, 0);
    tick();
    chk("std_rd2_dout", b_dout, 8'h22);
    tick();
    chk("std_rd3_udf",  b_udf, 1);
    chk("std_rd3_dout", b_dout, 8'h22);
    chk("std_rd3_empty", b_empty, 1);
    b_rd = 0; tick();
    chk("std_udf_once", b_udf, 0);
    for (int i = 0; i < 8; i++) begin
      b_wr = 1; b_din = 8'(8'hA0 + i); tick();
    end
    b_din = 8'hFF; tick(); b_wr = 0;
    chk("std_full", b_full, 1);
    chk("std_ovf",  b_ovf, 1);
    for (int i = 0; i < 8; i++) begin
      b_rd = 1; tick();
      chk("std_drain_dout", b_dout, 8'hA0 + i);
    end
    b_rd = 0;
    chk("std_drain_empty", b_empty, 1);

    // ---------------- custom almost thresholds ----------------
    for (int k = 0; k < 8; k++) begin
      chk("thr_fill_count",  c_count, k);
      chk("thr_fill_afull",  c_afull, (k >= 6));
      chk("thr_fill_aempty", c_aempty, (k <= 2));
      c_wr = 1; c_din = 8'(k); tick();
    end
    c_wr = 0;
    chk("thr_full_count",  c_count, 8);
    chk("thr_full_afull",  c_afull, 1);
    chk("thr_full_aempty", c_aempty, 0);
    for (int k = 8; k > 0; k--) begin
      c_rd = 1; tick();
      chk("thr_drain_count",  c_count, k - 1);
      chk("thr_drain_afull",  c_afull, ((k - 1) >= 6));
      chk("thr_drain_aempty", c_aempty, ((k - 1) <= 2));
    end
    c_rd = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
